// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc, ir and retire count
module cpu_sequencer #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [15:0]     instruction,
  input  logic            jump,
  input  logic            branch,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic            is_zero,
  input  logic [PC_W-1:0] target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            ir_load,
  output logic            reg_we,
  output logic            mem_we,
  output logic            mem_re,
  output logic [2:0]      state,
  output logic            halted,
  output logic            err,
  output logic [15:0]     retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ILL} state_t;
  localparam int CW = $clog2(MEM_TO + 1);
  state_t st;
  logic take, take_now, tk, adv;
  logic [CW-1:0] cnt;
  assign state = st;
  assign ir_load = st == FETCH;
  assign reg_we = st == WB;
  assign mem_we = (st == MEM) & memwrite & ~memtoreg;
  assign mem_re = (st == MEM) & memtoreg;
  assign halted = st == HALT;
  assign take_now = jump | (branch & is_zero);
  // the EXEC->FETCH path uses the live decode; later stages use the value latched in EXEC
  always_comb begin
    tk = st == EXEC ? take_now : take;
    adv = (st == EXEC & ~memwrite & ~memtoreg & ~regwrite) |
          (st == MEM & mem_ready & ~memtoreg) | (st == WB);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      retired <= '0;
      err <= 1'b0;
      take <= 1'b0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (run) st <= FETCH;
        FETCH: begin
          ir <= instruction;
          st <= DECODE;
        end
        DECODE: st <= ir == HALT_WORD ? HALT : EXEC;
        EXEC: begin
          take <= take_now;
          cnt <= '0;
          st <= (memwrite | memtoreg) ? MEM : regwrite ? WB : FETCH;
        end
        MEM:
          if (mem_ready) st <= memtoreg ? WB : FETCH;
          else if (cnt == CW'(MEM_TO - 1)) begin
            st <= HALT;
            err <= 1'b1;
          end else cnt <= cnt + 1'b1;
        WB: st <= FETCH;
        HALT: ;
        default: begin
          st <= HALT;
          err <= 1'b1;
        end
      endcase
      if (adv) begin
        pc <= tk ? target : pc + 1'b1;
        retired <= retired + 16'd1;
      end
    end
  end
endmodule
